// File: rtl/io_input_debouncer.sv
// rtl/io_input_debouncer.sv - pin conditioning: 2-FF sync, polarity fix, counter debounce, edge strobes
// Each channel is filtered independently; level_o only moves after DEBOUNCE_CYCLES disagreeing samples.
module io_input_debouncer #(
   parameter int              N_CH            = 13,
   parameter int              DEBOUNCE_CYCLES = 1000000,
   parameter logic [N_CH-1:0] INVERT_MASK     = N_CH'(13'h000F)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N_CH-1:0] raw_i,
   output logic [N_CH-1:0] level_o,
   output logic [N_CH-1:0] rise_o,
   output logic [N_CH-1:0] fall_o
);

   localparam int              CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_CH-1:0]             sync1;
   logic [N_CH-1:0]             sync2;
   logic [N_CH-1:0]             s;
   logic [N_CH-1:0][CNT_W-1:0]  cnt;

   assign s = sync2 ^ INVERT_MASK;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // Sync stages reset to the idle pin value so no phantom change is seen on exit.
         sync1   <= INVERT_MASK;
         sync2   <= INVERT_MASK;
         cnt     <= '0;
         level_o <= '0;
         rise_o  <= '0;
         fall_o  <= '0;
      end else begin
         sync1 <= raw_i;
         sync2 <= sync1;
         for (int i = 0; i < N_CH; i++) begin
            rise_o[i] <= 1'b0;
            fall_o[i] <= 1'b0;
            if (s[i] == level_o[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
               level_o[i] <= s[i];
               cnt[i]     <= '0;
               rise_o[i]  <= s[i];
               fall_o[i]  <= ~s[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/io_input_debouncer.md
Name: io_input_debouncer

Overview:
- Conditioning stage between the DE-board pins (KEY, SW) and the core's io_btn_i / io_sw_i inputs.
- Per channel: 2-FF synchroniser, optional polarity inversion, counter-based debounce filter, and one-cycle rise/fall pulses.
- Gives the core clean, logically active-high levels and the top level clean edge strobes. Sits beside the reset synchroniser in the board wrapper.

Parameters:
- N_CH, 13, number of channels (KEY[3:0] on bits 3:0, SW[8:0] on bits 12:4).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (20 ms at 50 MHz); legal range >= 1.
- INVERT_MASK, 13'h000F, bit i = 1 means channel i is active-low at the pin (KEYs) and is inverted after synchronisation.
- CNT_W (localparam), $clog2(DEBOUNCE_CYCLES+1), counter width.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- raw_i  input  N_CH  asynchronous pin inputs.
- level_o  output  N_CH  debounced logical level (1 = pressed / switch up).
- rise_o  output  N_CH  one-cycle pulse on a 0->1 level_o change.
- fall_o  output  N_CH  one-cycle pulse on a 1->0 level_o change.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - sync1/sync2 <= INVERT_MASK (pin idle value).
  - All counters <= 0.
  - level_o, rise_o, fall_o <= 0.
  - Reset asserted mid-count discards the partial count; no pulse is emitted on reset exit.
- Synchroniser: sync1 <= raw_i; sync2 <= sync1. Logical sample s = sync2 ^ INVERT_MASK.
- Per-channel filter, independent per bit, evaluated every cycle:
  - s == level: cnt <= 0; no pulse.
  - s != level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != level and cnt == DEBOUNCE_CYCLES-1: level <= s; cnt <= 0; rise or fall pulse.
- Bounce: any cycle with s == level restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES never reach level_o.
- Pulse timing:
  - rise_o/fall_o are registered and assert on the same cycle level_o first shows the new value.
  - They are high for exactly one cycle, then return to 0.
  - rise and fall are never both high on the same channel.
- Latency: count the edge that first captures the new raw value into sync1 as edge 1. level_o updates at edge DEBOUNCE_CYCLES+2, provided raw is held stable throughout.
- DEBOUNCE_CYCLES = 1: level follows s one cycle after s differs, giving a pure 3-cycle synchronised path.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Channels are fully independent: simultaneous changes on several bits produce simultaneous pulses.

Test Plan:
1. Reset, pins idle (raw_i = 13'h000F), DEBOUNCE_CYCLES = 4: hold rst_i for 3 cycles, release, run 20 cycles -> level_o = 0, rise_o = fall_o = 0 throughout.
2. Clean press: drive raw_i[0] = 0 (KEY0 pressed) and hold -> level_o[0] = 1 at edge 6; rise_o[0] = 1 for exactly that one cycle. Release (raw_i[0] = 1) -> level_o[0] = 0 six edges later, with a single fall_o[0] pulse.
3. Bounce: raw_i[4] toggles 1,0,1,0 with 2-cycle periods, then holds 1 -> no pulse during the bounce; level_o[4] = 1 exactly 6 edges after the final stable transition; one rise_o[4] pulse.
4. Short glitch: raw_i[12] high for 3 cycles only (DEBOUNCE_CYCLES = 4) -> level_o[12] stays 0; rise_o[12] and fall_o[12] never assert.
5. Simultaneous events: raw_i[1] = 0 and raw_i[5] = 1 on the same edge -> level_o[1] and level_o[5] both go to 1 at edge 6, with rise_o = 13'h0022 for one cycle.
6. Reset mid-operation: start a change on raw_i[7], assert rst_i when the counter = 2, release after 1 cycle -> no pulse, level_o[7] = 0. The count restarts, and level_o[7] = 1 follows DEBOUNCE_CYCLES+2 edges after reset release if raw is still held (sync regs re-capture from reset value).
